// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
// No logic here, so there is no latency and no backpressure.
// Holds the FSM state encoding, the port indices and the starve counter width.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

    localparam int STARVE_W = 4;

endpackage

// File: rtl/dmem_arb_if.sv
// Bundle for the CPU port, the DMA/debug port and the single-port RAM side.
// Latency and backpressure are set by the arbiter; each port is held until its rdy pulse.
// The slave modport is the arbiter's view; the master modport is the requesters' and RAM's view.
interface dmem_arb_if #(
    parameter int bus_addr_data_width = 8
);
    logic                           c_re;
    logic                           c_we;
    logic [bus_addr_data_width-1:0] c_addr;
    logic [7:0]                     c_wdata;
    logic [7:0]                     c_rdata;
    logic                           c_rdy;

    logic                           d_re;
    logic                           d_we;
    logic [bus_addr_data_width-1:0] d_addr;
    logic [7:0]                     d_wdata;
    logic [7:0]                     d_rdata;
    logic                           d_rdy;

    logic                           dmem_re;
    logic                           dmem_we;
    logic [bus_addr_data_width-1:0] dmem_a;
    logic [7:0]                     dmem_w;
    logic [7:0]                     dmem_r;

    modport slave (
        input  c_re, c_we, c_addr, c_wdata,
        output c_rdata, c_rdy,
        input  d_re, d_we, d_addr, d_wdata,
        output d_rdata, d_rdy,
        output dmem_re, dmem_we, dmem_a, dmem_w,
        input  dmem_r
    );

    modport master (
        output c_re, c_we, c_addr, c_wdata,
        input  c_rdata, c_rdy,
        output d_re, d_we, d_addr, d_wdata,
        input  d_rdata, d_rdy,
        input  dmem_re, dmem_we, dmem_a, dmem_w,
        output dmem_r
    );

endinterface

// File: rtl/dmem_arb_pick.sv
// Combinational winner select between the CPU and DMA ports (DMEM_ARB_RR_EN picks round-robin).
// Latency: zero, purely combinational.
// Backpressure: none; the winner is only meaningful while at least one port requests.
module dmem_arb_pick
    import dmem_arb_pkg::*;
#(
    parameter int max_wait = 4
) (
    input  logic                c_req,
    input  logic                d_req,
`ifdef DMEM_ARB_RR_EN
    input  logic                last_grant,
`else
    input  logic [STARVE_W-1:0] starve_cnt,
`endif
    output logic                win
);

`ifdef DMEM_ARB_RR_EN
    always_comb begin
        win = PORT_CPU;
        if (c_req && d_req) begin
            win = ~last_grant;
        end else if (d_req) begin
            win = PORT_DMA;
        end
    end
`else
    localparam logic [STARVE_W-1:0] MAX_WAIT_W = STARVE_W'(max_wait);

    // The CPU keeps priority until the DMA port has waited out its allowance.
    always_comb begin
        win = PORT_CPU;
        if (d_req && (!c_req || (starve_cnt == MAX_WAIT_W))) begin
            win = PORT_DMA;
        end
    end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter onto one byte-wide RAM; DMEM_ARB_RR_EN selects round-robin instead of fixed priority.
// Latency: request seen in IDLE -> RAM strobe next cycle -> rdy the cycle after; one access per 3 cycles.
// Backpressure: the losing port simply keeps its request asserted until its own rdy pulse.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int bus_addr_data_width = 8,
    parameter int max_wait            = 4
) (
    input  logic        clk,
    input  logic        rst,
    dmem_arb_if.slave   bus
);

    state_t                         state_q, state_d;
    logic                           owner_q, owner_d;
    logic [7:0]                     c_rdata_q, c_rdata_d;
    logic [7:0]                     d_rdata_q, d_rdata_d;
`ifdef DMEM_ARB_RR_EN
    logic                           last_q, last_d;
`else
    logic [STARVE_W-1:0]            starve_q, starve_d;
`endif

    logic                           c_req, d_req, win;
    logic                           o_re, o_we;
    logic [bus_addr_data_width-1:0] o_addr;
    logic [7:0]                     o_wdata;

    assign c_req = bus.c_re | bus.c_we;
    assign d_req = bus.d_re | bus.d_we;

    dmem_arb_pick #(
        .max_wait   (max_wait)
    ) u_pick (
        .c_req      (c_req),
        .d_req      (d_req),
`ifdef DMEM_ARB_RR_EN
        .last_grant (last_q),
`else
        .starve_cnt (starve_q),
`endif
        .win        (win)
    );

    always_comb begin
        o_re    = bus.c_re;
        o_we    = bus.c_we;
        o_addr  = bus.c_addr;
        o_wdata = bus.c_wdata;
        if (owner_q == PORT_DMA) begin
            o_re    = bus.d_re;
            o_we    = bus.d_we;
            o_addr  = bus.d_addr;
            o_wdata = bus.d_wdata;
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        c_rdata_d = c_rdata_q;
        d_rdata_d = d_rdata_q;
`ifdef DMEM_ARB_RR_EN
        last_d    = last_q;
`else
        starve_d  = starve_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (c_req || d_req) begin
                    owner_d = win;
                    state_d = ACC;
`ifdef DMEM_ARB_RR_EN
                    last_d  = win;
`endif
                end
`ifndef DMEM_ARB_RR_EN
                // Counts only CPU wins that overtook a waiting DMA request.
                if (!d_req || (win == PORT_DMA)) begin
                    starve_d = '0;
                end else if (starve_q != '1) begin
                    starve_d = starve_q + STARVE_W'(1);
                end
`endif
            end
            ACC: begin
                state_d = DONE;
                if (o_re && !o_we) begin
                    if (owner_q == PORT_DMA) begin
                        d_rdata_d = bus.dmem_r;
                    end else begin
                        c_rdata_d = bus.dmem_r;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            owner_q   <= PORT_CPU;
            c_rdata_q <= '0;
            d_rdata_q <= '0;
`ifdef DMEM_ARB_RR_EN
            last_q    <= PORT_DMA;
`else
            starve_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            c_rdata_q <= c_rdata_d;
            d_rdata_q <= d_rdata_d;
`ifdef DMEM_ARB_RR_EN
            last_q    <= last_d;
`else
            starve_q  <= starve_d;
`endif
        end
    end

    assign bus.dmem_re = (state_q == ACC) && o_re && !o_we;
    assign bus.dmem_we = (state_q == ACC) && o_we;
    assign bus.dmem_a  = (state_q == ACC) ? o_addr  : '0;
    assign bus.dmem_w  = (state_q == ACC) ? o_wdata : '0;

    assign bus.c_rdy   = (state_q == DONE) && (owner_q == PORT_CPU);
    assign bus.d_rdy   = (state_q == DONE) && (owner_q == PORT_DMA);
    assign bus.c_rdata = c_rdata_q;
    assign bus.d_rdata = d_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed accesses against a slot-level access model and a byte RAM.
// Define DMEM_ARB_RR_EN for both bench and RTL to exercise the round-robin build.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int AW   = 8;
    localparam int MAXW = 4;
`ifdef DMEM_ARB_RR_EN
    localparam int D_GAP = 6;
`else
    localparam int D_GAP = 15;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dmem_arb_if #(.bus_addr_data_width(AW)) bus ();

    dmem_arbiter #(
        .bus_addr_data_width (AW),
        .max_wait            (MAXW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [7:0] init_val(input logic [7:0] a);
        return (a == 8'h20) ? 8'h33 : (a ^ 8'h5C);
    endfunction

    // RAM seen by the DUT: combinational read, write on the clock edge.
    bit [7:0] ram     [256];
    bit       ram_vld [256];
    assign bus.dmem_r = ram_vld[bus.dmem_a] ? ram[bus.dmem_a] : init_val(bus.dmem_a);
    always @(posedge clk) begin
        if (bus.dmem_we) begin
            ram[bus.dmem_a]     <= bus.dmem_w;
            ram_vld[bus.dmem_a] <= 1'b1;
        end
    end

    // Access model: each granted access is a 3-slot job (arbitrate, strobe, report).
    int         m_phase = 0;
    logic       m_own   = 1'b0;
    logic       m_re = 1'b0, m_we = 1'b0;
    logic [7:0] m_addr = 8'h0, m_wdata = 8'h0;
    logic [7:0] m_rdata [2];
    bit   [7:0] shadow     [256];
    bit         shadow_vld [256];
    int         m_consec = 0;
    logic       m_last   = 1'b1;
    logic       mc_req, md_req, m_win;

    assign mc_req = bus.c_re | bus.c_we;
    assign md_req = bus.d_re | bus.d_we;
    always_comb begin
`ifdef DMEM_ARB_RR_EN
        m_win = (mc_req && md_req) ? !m_last : md_req;
`else
        m_win = (mc_req && md_req) ? (m_consec == MAXW) : md_req;
`endif
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_phase    <= 0;
            m_own      <= 1'b0;
            m_rdata[0] <= 8'h0;
            m_rdata[1] <= 8'h0;
            m_consec   <= 0;
            m_last     <= 1'b1;
        end else begin
            case (m_phase)
                0: begin
                    if (mc_req || md_req) begin
                        m_phase <= 1;
                        m_own   <= m_win;
                        m_re    <= m_win ? bus.d_re    : bus.c_re;
                        m_we    <= m_win ? bus.d_we    : bus.c_we;
                        m_addr  <= m_win ? bus.d_addr  : bus.c_addr;
                        m_wdata <= m_win ? bus.d_wdata : bus.c_wdata;
`ifdef DMEM_ARB_RR_EN
                        m_last  <= m_win;
`endif
                    end
`ifndef DMEM_ARB_RR_EN
                    if (!md_req || m_win) m_consec <= 0;
                    else if (m_consec < 15) m_consec <= m_consec + 1;
`endif
                end
                1: begin
                    if (m_we) begin
                        shadow[m_addr]     <= m_wdata;
                        shadow_vld[m_addr] <= 1'b1;
                    end else if (m_re) begin
                        m_rdata[m_own] <= shadow_vld[m_addr] ? shadow[m_addr] : init_val(m_addr);
                    end
                    m_phase <= 2;
                end
                default: m_phase <= 0;
            endcase
        end
    end

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit log_en  = 1'b0;
    bit c_seen  = 1'b0;
    bit d_seen  = 1'b0;
    int grant_port [$];
    int grant_cyc  [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 30)
                $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [35:0] dut_vec();
        return {bus.dmem_re, bus.dmem_we, bus.dmem_a, bus.dmem_w,
                bus.c_rdy, bus.d_rdy, bus.c_rdata, bus.d_rdata};
    endfunction

    function automatic logic [35:0] model_vec();
        return {(m_phase == 1) && m_re && !m_we, (m_phase == 1) && m_we,
                (m_phase == 1) ? m_addr : 8'h0, (m_phase == 1) ? m_wdata : 8'h0,
                (m_phase == 2) && !m_own, (m_phase == 2) && m_own,
                m_rdata[0], m_rdata[1]};
    endfunction

    task automatic access(input bit port, input bit re, input bit we,
                          input logic [7:0] addr, input logic [7:0] wd,
                          output int st_off, output int rdy_off,
                          output bit st_re, output bit st_we);
        st_off = -1; rdy_off = -1; st_re = 1'b0; st_we = 1'b0;
        @(posedge clk); #1;
        if (!port) begin
            bus.c_re = re; bus.c_we = we; bus.c_addr = addr; bus.c_wdata = wd;
        end else begin
            bus.d_re = re; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wd;
        end
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (st_off < 0 && (bus.dmem_re || bus.dmem_we)) begin
                st_off = k; st_re = bus.dmem_re; st_we = bus.dmem_we;
            end
            if (port ? bus.d_rdy : bus.c_rdy) begin
                rdy_off = k;
                break;
            end
        end
        @(posedge clk); #1;
        if (!port) begin bus.c_re = 1'b0; bus.c_we = 1'b0; end
        else       begin bus.d_re = 1'b0; bus.d_we = 1'b0; end
    endtask

    initial begin
        int  so, ro, nrdy;
        bit  sr, sw;
        int  d_first, d_second, c_first, c_second;
        int  exp_seq [10];

        rst = 1'b0;
        bus.c_re = 1'b0; bus.c_we = 1'b0; bus.c_addr = 8'h0; bus.c_wdata = 8'h0;
        bus.d_re = 1'b0; bus.d_we = 1'b0; bus.d_addr = 8'h0; bus.d_wdata = 8'h0;

        fork
            forever begin
                @(negedge clk);
                check("cycle_vs_model", 64'(dut_vec()), 64'(model_vec()));
                if (bus.c_rdy) c_seen = 1'b1;
                if (bus.d_rdy) d_seen = 1'b1;
                if (log_en && bus.c_rdy) begin grant_port.push_back(0); grant_cyc.push_back(cyc); end
                if (log_en && bus.d_rdy) begin grant_port.push_back(1); grant_cyc.push_back(cyc); end
                cyc++;
            end
        join_none

        repeat (3) @(negedge clk);
        check("reset_outputs", 64'(dut_vec()), 64'h0);
        #2 rst = 1'b1;

        // Write then read back on the CPU port.
        d_seen = 1'b0;
        access(1'b0, 1'b0, 1'b1, 8'h10, 8'h5A, so, ro, sr, sw);
        check("wr_strobe_offset", 64'(so), 64'd1);
        check("wr_strobe_we", 64'({sr, sw}), 64'b01);
        check("wr_rdy_offset", 64'(ro), 64'd2);
        access(1'b0, 1'b1, 1'b0, 8'h10, 8'h00, so, ro, sr, sw);
        check("rd_rdy_offset", 64'(ro), 64'd2);
        check("rd_c_rdata", 64'(bus.c_rdata), 64'h5A);
        check("no_d_rdy", 64'(d_seen), 64'd0);

        // re and we together behave as a write.
        access(1'b0, 1'b1, 1'b1, 8'h08, 8'hC3, so, ro, sr, sw);
        check("rewe_strobes", 64'({sr, sw}), 64'b01);
        access(1'b0, 1'b1, 1'b0, 8'h08, 8'h00, so, ro, sr, sw);
        check("rewe_readback", 64'(bus.c_rdata), 64'hC3);

        // Reset in the middle of a write aborts it.
        @(posedge clk); #1;
        bus.c_we = 1'b1; bus.c_addr = 8'h40; bus.c_wdata = 8'h77;
        @(negedge clk);
        @(negedge clk);
        check("abort_in_acc", 64'(bus.dmem_we), 64'd1);
        #2 rst = 1'b0;
        #1 check("abort_outputs_zero", 64'(dut_vec()), 64'h0);
        bus.c_we = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        c_seen = 1'b0;
        repeat (6) @(negedge clk);
        check("abort_no_c_rdy", 64'(c_seen), 64'd0);
        access(1'b0, 1'b1, 1'b0, 8'h40, 8'h00, so, ro, sr, sw);
        check("abort_ram_untouched", 64'(bus.c_rdata), 64'h1C);
        access(1'b0, 1'b1, 1'b0, 8'h10, 8'h00, so, ro, sr, sw);
        check("recover_rdy_offset", 64'(ro), 64'd2);
        check("recover_c_rdata", 64'(bus.c_rdata), 64'h5A);

        // DMA port read leaves CPU read data alone.
        access(1'b1, 1'b1, 1'b0, 8'h20, 8'h00, so, ro, sr, sw);
        check("dma_rdy_offset", 64'(ro), 64'd2);
        check("dma_d_rdata", 64'(bus.d_rdata), 64'h33);
        check("dma_c_rdata_kept", 64'(bus.c_rdata), 64'h5A);

        // Both ports reading back to back.
        grant_port.delete(); grant_cyc.delete();
        @(posedge clk); #1;
        bus.c_re = 1'b1; bus.c_addr = 8'h10;
        bus.d_re = 1'b1; bus.d_addr = 8'h08;
        log_en = 1'b1;
        nrdy = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus.c_rdy || bus.d_rdy) nrdy++;
            if (nrdy == 12) break;
        end
        @(posedge clk); #1;
        bus.c_re = 1'b0; bus.d_re = 1'b0;
        repeat (4) @(negedge clk);
        log_en = 1'b0;
`ifdef DMEM_ARB_RR_EN
        exp_seq = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
`else
        exp_seq = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
`endif
        check("grant_count", 64'(grant_port.size() >= 10), 64'd1);
        if (grant_port.size() >= 10) begin
            for (int i = 0; i < 10; i++)
                check($sformatf("grant_order[%0d]", i), 64'(grant_port[i]), 64'(exp_seq[i]));
        end
        d_first = -1; d_second = -1; c_first = -1; c_second = -1;
        for (int i = 0; i < grant_port.size(); i++) begin
            if (grant_port[i] == 1) begin
                if (d_first < 0) d_first = grant_cyc[i];
                else if (d_second < 0) d_second = grant_cyc[i];
            end else begin
                if (c_first < 0) c_first = grant_cyc[i];
                else if (c_second < 0) c_second = grant_cyc[i];
            end
        end
        check("d_rdy_period", 64'(d_second - d_first), 64'(D_GAP));
`ifdef DMEM_ARB_RR_EN
        check("c_rdy_period", 64'(c_second - c_first), 64'd6);
`else
        check("c_rdy_period", 64'(c_second - c_first), 64'd3);
`endif

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t expected end before 200000", $time);
        $fatal(1, "watchdog");
    end

endmodule
